sa_tile_streamer: RTL and testbench
===================================

Name: sa_tile_streamer

Overview:
Hardware tile sequencer and operand feeder for systolic_array_top. It moves the testbench's tiling and per-lane K-streaming into RTL: iterates (m0, c0) tiles over runtime M×COUT, fetches T[m][k] and W[k][c] per lane from an asynchronous-read scratchpad and zero-pads out-of-range lanes. Per tile it pulses start_mul, streams while stall_mul, drains, then hands the tile to a readout agent via valid/ready.

Parameters:
N, 64, lanes (systolic array dimension; must match SA_N)
ADDR_W, 32, byte-address width
DATA_W, 32, operand width (FP32 bit pattern, word_t)
DIM_W, 16, width of runtime dimension registers
DRAIN_CYCLES, 128, post-stream drain cycles before tile is offered (≥ 2*N)
TIMEOUT_CYCLES, 200000, watchdog limit (only with SA_STREAM_WDOG_EN)

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse; latches cfg_* and begins job (ignored while busy)
cfg_m  in  DIM_W  rows of T (im2col M)
cfg_k  in  DIM_W  reduction depth K
cfg_cout  in  DIM_W  output channels
cfg_x_base  in  ADDR_W  byte base of T, row-major [M][K]
cfg_w_base  in  ADDR_W  byte base of W, row-major [K][COUT]
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
err_timeout  out  1  sticky watchdog error, cleared by cfg_start
start_mul  out  1  to DUT
stall_mul  in  1  from DUT; high while array consumes operands
sc_valid_queue  in  N  per-lane operand request from DUT
sc_x_data  out  N*DATA_W  per-lane X operand
sc_w_data  out  N*DATA_W  per-lane W operand
x_rd_en  out  N  per-lane X scratchpad read
x_rd_addr  out  N*ADDR_W  per-lane X address
x_rd_data  in  N*DATA_W  X read data, combinational (same cycle)
w_rd_en  out  N  per-lane W read
w_rd_addr  out  N*ADDR_W  per-lane W address
w_rd_data  in  N*DATA_W  W read data, same cycle
tile_valid  out  1  tile results stable in array psum
tile_ready  in  1  readout agent accepted tile
tile_m0  out  DIM_W  row origin of offered tile
tile_c0  out  DIM_W  channel origin of offered tile

Behaviour:
- Reset: state IDLE; busy, done, err_timeout, start_mul, tile_valid, x_rd_en, w_rd_en = 0; sc_x_data, sc_w_data, addresses, tile_m0, tile_c0 = 0; all k pointers = 0. Reset mid-job aborts immediately, no done.
- FSM: IDLE → (cfg_start) LOAD → START → WAIT → STREAM → DRAIN → OFFER → NEXT → START… / DONE → IDLE.
- LOAD: latch cfg; m0=c0=0; clear pointers; busy=1. Any of cfg_m/k/cout == 0 → DONE directly, no start_mul.
- START: start_mul=1 exactly one cycle. WAIT: wait for stall_mul=1, then STREAM.
- STREAM, per lane i: in_x = (m0+i<cfg_m) && (kx[i]<cfg_k); in_w = (c0+i<cfg_cout) && (kw[i]<cfg_k).
  x_rd_en[i]=sc_valid_queue[i]&&in_x; x_rd_addr[i]=x_base+((m0+i)*cfg_k+kx[i])*4; sc_x_data[i]=x_rd_en[i]?x_rd_data[i]:0 (combinational). kx[i]++ at edge when x_rd_en[i]. W symmetric: addr=w_base+(kw[i]*cfg_cout+c0+i)*4. Address arithmetic modulo 2^ADDR_W. Pointers saturate at cfg_k (further requests get zero). Lanes idle → data 0.
- stall_mul falls → DRAIN, count DRAIN_CYCLES, then OFFER.
- OFFER: tile_valid=1 with tile_m0/c0 held until tile_ready; same-cycle valid&ready completes transfer. tile_ready while not OFFER ignored.
- NEXT: c0+=N; if c0≥cfg_cout then c0=0, m0+=N; if m0≥cfg_m → DONE else clear pointers → START. Order: c0 inner, m0 outer.
- DONE: done=1 one cycle, busy=0, → IDLE. cfg_start in same cycle ignored; accepted from IDLE next cycle.

Optional Feature:
SA_STREAM_WDOG_EN: defined → cycle counter in WAIT+STREAM; reaching TIMEOUT_CYCLES sets err_timeout, pulses done, → IDLE. Undefined → no counter, err_timeout tied 0, FSM waits indefinitely.

Test Plan:
- M=128,K=363,COUT=32, N=64, model DUT: 2 tiles (0,0),(64,0); each lane 0..31 gets 363 W words; lanes 32..63 W=0; Y matches reference matmul bit-exact per psum readout.
- M=70,K=5,COUT=70: 4 tiles in order (0,0),(0,64),(64,0),(64,64); lanes m≥70/c≥70 never assert rd_en.
- Lane 3 requests 8 times with K=5: exactly 5 x_rd_en pulses, addrs x_base+(3*5+0..4)*4, last 3 data=0.
- cfg_k=0: done 2 cycles after cfg_start, start_mul never asserted.
- tile_ready held low 50 cycles in OFFER: tile_valid/m0/c0 stable, no start_mul; n_rst mid-STREAM → all outputs 0, IDLE.
- With SA_STREAM_WDOG_EN, TIMEOUT_CYCLES=100, stall_mul stuck 1: err_timeout=1 and done pulse at cycle 100 of WAIT+STREAM.

Source files
------------

// File: rtl/sa_tile_streamer.sv
// sa_tile_streamer: tile sequencer and per-lane operand feeder for systolic_array_top.
//
// Walks the output space in (m0, c0) tiles of N x N, with c0 as the inner loop and m0
// as the outer loop. For each tile it pulses start_mul and waits for the array to raise
// stall_mul. While stall_mul is high, each lane serves its operand requests from the
// scratchpad, and lanes that fall outside the matrices return zero. After stall_mul
// falls it drains for DRAIN_CYCLES and then offers the tile on a valid/ready handshake.
//
// Optional build macro: SA_STREAM_WDOG_EN
//    When defined, a watchdog counts the cycles spent in WAIT and STREAM. When the count
//    reaches TIMEOUT_CYCLES it sets err_timeout and ends the job with a done pulse.
//    When undefined, err_timeout is tied low and the FSM waits indefinitely.
//
// Ports
//    clk, n_rst                      clock (rising edge), asynchronous active-low reset
//    cfg_start                       one-cycle job start; latches cfg_*; ignored while busy
//    cfg_m/cfg_k/cfg_cout            runtime M, K, COUT
//    cfg_x_base/cfg_w_base           byte bases of T[M][K] and W[K][COUT], both row-major
//    busy, done, err_timeout         job status
//    start_mul, stall_mul            array handshake
//    sc_valid_queue                  per-lane operand requests from the array
//    sc_x_data/sc_w_data             per-lane operands, zero when the lane is not served
//    x_/w_rd_en, _rd_addr, _rd_data  per-lane scratchpad reads (read data arrives in the
//                                    same cycle)
//    tile_valid/ready, tile_m0/c0    tile hand-off to the readout agent
module sa_tile_streamer #(
   parameter int N              = 64,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int DIM_W          = 16,
   parameter int DRAIN_CYCLES   = 128,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                cfg_start,
   input  logic [DIM_W-1:0]    cfg_m,
   input  logic [DIM_W-1:0]    cfg_k,
   input  logic [DIM_W-1:0]    cfg_cout,
   input  logic [ADDR_W-1:0]   cfg_x_base,
   input  logic [ADDR_W-1:0]   cfg_w_base,
   output logic                busy,
   output logic                done,
   output logic                err_timeout,
   output logic                start_mul,
   input  logic                stall_mul,
   input  logic [N-1:0]        sc_valid_queue,
   output logic [N*DATA_W-1:0] sc_x_data,
   output logic [N*DATA_W-1:0] sc_w_data,
   output logic [N-1:0]        x_rd_en,
   output logic [N*ADDR_W-1:0] x_rd_addr,
   input  logic [N*DATA_W-1:0] x_rd_data,
   output logic [N-1:0]        w_rd_en,
   output logic [N*ADDR_W-1:0] w_rd_addr,
   input  logic [N*DATA_W-1:0] w_rd_data,
   output logic                tile_valid,
   input  logic                tile_ready,
   output logic [DIM_W-1:0]    tile_m0,
   output logic [DIM_W-1:0]    tile_c0
);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_STREAM, S_DRAIN, S_OFFER, S_NEXT, S_DONE
   } state_t;

   localparam logic [DIM_W-1:0] DIM_ZERO  = {DIM_W{1'b0}};
   localparam logic [DIM_W-1:0] DIM_ONE   = {{(DIM_W-1){1'b0}}, 1'b1};
   localparam logic [DIM_W:0]   TILE_STEP = (DIM_W+1)'(N);
   localparam logic [31:0]      DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

   // Parameter sanity: draining must outlast the array pipeline.
   if (DRAIN_CYCLES < 2 * N || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("sa_tile_streamer: DRAIN_CYCLES must be >= 2*N and TIMEOUT_CYCLES >= 1");
   end

   state_t            state_r, state_s;
   logic [DIM_W-1:0]  m_r, k_r, cout_r;
   logic [ADDR_W-1:0] x_base_r, w_base_r;
   logic [DIM_W-1:0]  m0_r, c0_r;
   logic [31:0]       drain_cnt_r;
   logic              busy_r, done_r, start_mul_r, tile_valid_r;
   logic [DIM_W:0]    c0_nxt_s, m0_nxt_s;
   logic              cfg_zero_s, clr_ptr_s, streaming_s, wdog_hit_s, accept_s;

   // Next-tile origins are computed one bit wider so that stepping past the last tile cannot wrap.
   assign c0_nxt_s    = {1'b0, c0_r} + TILE_STEP;
   assign m0_nxt_s    = {1'b0, m0_r} + TILE_STEP;
   assign cfg_zero_s  = (m_r == DIM_ZERO) || (k_r == DIM_ZERO) || (cout_r == DIM_ZERO);
   assign clr_ptr_s   = (state_r == S_LOAD) || (state_r == S_NEXT);
   assign streaming_s = (state_r == S_STREAM);
   assign accept_s    = (state_r == S_IDLE) && cfg_start;

   // Next-state logic of the tile sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE:   if (cfg_start) state_s = S_LOAD; else state_s = S_IDLE;
         S_LOAD:   if (cfg_zero_s) state_s = S_DONE; else state_s = S_START;
         S_START:  state_s = S_WAIT;
         S_WAIT: begin
            if (wdog_hit_s)     state_s = S_DONE;
            else if (stall_mul) state_s = S_STREAM;
            else                state_s = S_WAIT;
         end
         S_STREAM: begin
            if (wdog_hit_s)      state_s = S_DONE;
            else if (!stall_mul) state_s = S_DRAIN;
            else                 state_s = S_STREAM;
         end
         S_DRAIN:  if (drain_cnt_r == DRAIN_LAST) state_s = S_OFFER; else state_s = S_DRAIN;
         S_OFFER:  if (tile_ready) state_s = S_NEXT; else state_s = S_OFFER;
         S_NEXT: begin
            // c0 is the inner loop: wrapping c0 advances m0, and m0 running out ends the job.
            if (c0_nxt_s >= {1'b0, cout_r}) begin
               if (m0_nxt_s >= {1'b0, m_r}) state_s = S_DONE;
               else                         state_s = S_START;
            end else begin
               state_s = S_START;
            end
         end
         S_DONE:   state_s = S_IDLE;
         default:  state_s = S_IDLE;
      endcase
   end

   // State register, job configuration, tile origins, drain counter, and the status outputs
   // (decoded from the next state so that they come straight from flops).
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r      <= S_IDLE;
         m_r          <= DIM_ZERO;
         k_r          <= DIM_ZERO;
         cout_r       <= DIM_ZERO;
         x_base_r     <= {ADDR_W{1'b0}};
         w_base_r     <= {ADDR_W{1'b0}};
         m0_r         <= DIM_ZERO;
         c0_r         <= DIM_ZERO;
         drain_cnt_r  <= 32'd0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         start_mul_r  <= 1'b0;
         tile_valid_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         busy_r       <= (state_s != S_IDLE) && (state_s != S_DONE);
         done_r       <= (state_s == S_DONE);
         start_mul_r  <= (state_s == S_START);
         tile_valid_r <= (state_s == S_OFFER);
         if (accept_s) begin
            m_r      <= cfg_m;
            k_r      <= cfg_k;
            cout_r   <= cfg_cout;
            x_base_r <= cfg_x_base;
            w_base_r <= cfg_w_base;
         end
         if (state_r == S_LOAD) begin
            m0_r <= DIM_ZERO;
            c0_r <= DIM_ZERO;
         end else if ((state_r == S_NEXT) && (state_s == S_START)) begin
            if (c0_nxt_s >= {1'b0, cout_r}) begin
               c0_r <= DIM_ZERO;
               m0_r <= m0_nxt_s[DIM_W-1:0];
            end else begin
               c0_r <= c0_nxt_s[DIM_W-1:0];
            end
         end
         drain_cnt_r <= (state_r == S_DRAIN) ? drain_cnt_r + 32'd1 : 32'd0;
      end
   end

`ifdef SA_STREAM_WDOG_EN
   logic [31:0] wdog_cnt_r;
   logic        err_timeout_r;
   logic        in_wait_s;

   assign in_wait_s   = (state_r == S_WAIT) || (state_r == S_STREAM);
   assign wdog_hit_s  = in_wait_s && (wdog_cnt_r == 32'(TIMEOUT_CYCLES - 1));
   assign err_timeout = err_timeout_r;

   // Watchdog: counts the cycles of WAIT+STREAM for the current tile. The error flag is sticky
   // until the next accepted cfg_start.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wdog_cnt_r    <= 32'd0;
         err_timeout_r <= 1'b0;
      end else begin
         wdog_cnt_r <= in_wait_s ? wdog_cnt_r + 32'd1 : 32'd0;
         if (accept_s)        err_timeout_r <= 1'b0;
         else if (wdog_hit_s) err_timeout_r <= 1'b1;
         else                 err_timeout_r <= err_timeout_r;
      end
   end
`else
   assign wdog_hit_s  = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // Per-lane operand feed. Each lane keeps its own K pointers for X and W. A pointer stops at
   // cfg_k, so any further requests on that lane get zero data and no scratchpad read.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DIM_W-1:0]  kx_r, kw_r;
      logic [DIM_W:0]    row_s, col_s;
      logic              x_en_s, w_en_s;
      logic [ADDR_W-1:0] x_off_s, w_off_s;

      // Lane range test and word offset. Address arithmetic wraps modulo 2^ADDR_W.
      always_comb begin
         row_s   = {1'b0, m0_r} + (DIM_W+1)'(i);
         col_s   = {1'b0, c0_r} + (DIM_W+1)'(i);
         x_en_s  = streaming_s && sc_valid_queue[i] &&
                   (row_s < {1'b0, m_r}) && (kx_r < k_r);
         w_en_s  = streaming_s && sc_valid_queue[i] &&
                   (col_s < {1'b0, cout_r}) && (kw_r < k_r);
         x_off_s = ADDR_W'(row_s) * ADDR_W'(k_r) + ADDR_W'(kx_r);
         w_off_s = ADDR_W'(kw_r) * ADDR_W'(cout_r) + ADDR_W'(col_s);
      end

      assign x_rd_en[i] = x_en_s;
      assign w_rd_en[i] = w_en_s;
      assign x_rd_addr[i*ADDR_W +: ADDR_W] =
         x_en_s ? x_base_r + {x_off_s[ADDR_W-3:0], 2'b00} : {ADDR_W{1'b0}};
      assign w_rd_addr[i*ADDR_W +: ADDR_W] =
         w_en_s ? w_base_r + {w_off_s[ADDR_W-3:0], 2'b00} : {ADDR_W{1'b0}};
      assign sc_x_data[i*DATA_W +: DATA_W] =
         x_en_s ? x_rd_data[i*DATA_W +: DATA_W] : {DATA_W{1'b0}};
      assign sc_w_data[i*DATA_W +: DATA_W] =
         w_en_s ? w_rd_data[i*DATA_W +: DATA_W] : {DATA_W{1'b0}};

      // K pointers advance on each served request and restart for every job and every tile.
      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            kx_r <= DIM_ZERO;
            kw_r <= DIM_ZERO;
         end else if (clr_ptr_s) begin
            kx_r <= DIM_ZERO;
            kw_r <= DIM_ZERO;
         end else begin
            if (x_en_s) kx_r <= kx_r + DIM_ONE;
            if (w_en_s) kw_r <= kw_r + DIM_ONE;
         end
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign start_mul  = start_mul_r;
   assign tile_valid = tile_valid_r;
   assign tile_m0    = m0_r;
   assign tile_c0    = c0_r;

endmodule

// File: tb/tb_sa_tile_streamer.sv
// Self-checking bench for sa_tile_streamer. The bench plays the systolic array, the
// scratchpad and the readout agent. Jobs come from a table, and each table entry carries
// its expected tile count. Operand requests are random. The expected addresses and data
// come from a model that counts the words delivered to each lane.
module tb_sa_tile_streamer;
   localparam int N     = 64;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DIMW  = 16;
   localparam int DRAIN = 128;

   typedef struct {
      int          m;
      int          k;
      int          c;
      logic [31:0] xb;
      logic [31:0] wb;
      int          exp_tiles;
      int          hold_idx;   // index of the tile whose hand-off is delayed by 50 cycles
      bit          lane3;      // first tile starts with 8 lane-3-only requests
   } job_t;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              cfg_start;
   logic [DIMW-1:0]   cfg_m, cfg_k, cfg_cout;
   logic [AW-1:0]     cfg_x_base, cfg_w_base;
   logic              busy, done, err_timeout, start_mul, stall_mul;
   logic [N-1:0]      sc_valid_queue;
   logic [N*DW-1:0]   sc_x_data, sc_w_data, x_rd_data, w_rd_data;
   logic [N-1:0]      x_rd_en, w_rd_en;
   logic [N*AW-1:0]   x_rd_addr, w_rd_addr;
   logic              tile_valid, tile_ready;
   logic [DIMW-1:0]   tile_m0, tile_c0;

   int errors = 0;
   int checks = 0;
   int smul_cnt = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   sa_tile_streamer #(.N(N), .ADDR_W(AW), .DATA_W(DW), .DIM_W(DIMW),
                      .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(200000)) dut (
      .clk(clk), .n_rst(n_rst), .cfg_start(cfg_start), .cfg_m(cfg_m), .cfg_k(cfg_k),
      .cfg_cout(cfg_cout), .cfg_x_base(cfg_x_base), .cfg_w_base(cfg_w_base),
      .busy(busy), .done(done), .err_timeout(err_timeout), .start_mul(start_mul),
      .stall_mul(stall_mul), .sc_valid_queue(sc_valid_queue), .sc_x_data(sc_x_data),
      .sc_w_data(sc_w_data), .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr),
      .x_rd_data(x_rd_data), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
      .w_rd_data(w_rd_data), .tile_valid(tile_valid), .tile_ready(tile_ready),
      .tile_m0(tile_m0), .tile_c0(tile_c0));

   // Scratchpad contents are a fixed hash of the byte address.
   function automatic logic [31:0] x_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction
   function automatic logic [31:0] w_word(input logic [31:0] a);
      return (a * 32'h85EB_CA6B) ^ 32'hC3C3_1234;
   endfunction

   // Asynchronous-read scratchpad: returns data even when rd_en is low.
   always_comb begin
      x_rd_data = '0;
      w_rd_data = '0;
      for (int i = 0; i < N; i++) begin
         x_rd_data[i*DW +: DW] = x_word(x_rd_addr[i*AW +: AW]);
         w_rd_data[i*DW +: DW] = w_word(w_rd_addr[i*AW +: AW]);
      end
   end

   always @(negedge clk) begin
      if (start_mul) smul_cnt++;
      if (done) done_cnt++;
   end

   task automatic chk(input string name, input int idx, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got 'h%0h, required 'h%0h", name, idx, act, exp);
      end
   endtask

   task automatic check_idle(input int tag);
      chk("idle_busy", tag, busy, 0);
      chk("idle_done", tag, done, 0);
      chk("idle_start_mul", tag, start_mul, 0);
      chk("idle_tile_valid", tag, tile_valid, 0);
      chk("idle_err_timeout", tag, err_timeout, 0);
      chk("idle_x_rd_en", tag, 64'(x_rd_en), 0);
      chk("idle_w_rd_en", tag, 64'(w_rd_en), 0);
      chk("idle_x_data_ones", tag, $countones(sc_x_data), 0);
      chk("idle_w_data_ones", tag, $countones(sc_w_data), 0);
      chk("idle_x_addr_ones", tag, $countones(x_rd_addr), 0);
      chk("idle_w_addr_ones", tag, $countones(w_rd_addr), 0);
      chk("idle_tile_m0", tag, tile_m0, 0);
      chk("idle_tile_c0", tag, tile_c0, 0);
   endtask

   // Array model for one tile while stall_mul is high. Called right after the edge that
   // entered STREAM; returns just after a clock edge.
   task automatic stream_tile(input int m0, input int c0, input job_t j, input bit lane3);
      int nx[N];
      int nw[N];
      int extra = 0;
      int cyc = 0;
      int l3 = 0;
      logic [N-1:0] req;
      logic [31:0]  a;
      bit ex, ew, pending;
      for (int i = 0; i < N; i++) begin nx[i] = 0; nw[i] = 0; end
      while (extra < 4 && cyc < 4000) begin
         pending = 0;
         for (int i = 0; i < N; i++)
            if ((m0 + i < j.m && nx[i] < j.k) || (c0 + i < j.c && nw[i] < j.k)) pending = 1;
         if (lane3 && cyc < 8) begin
            req = '0;
            req[3] = 1'b1;
         end else if (!pending) begin
            req = '1;          // every lane over-requests: must get zeros
            extra++;
         end else begin
            req = {$urandom, $urandom};
         end
         sc_valid_queue = req;
         tile_ready = 1'($urandom_range(0, 1));   // ignored outside OFFER
         @(negedge clk);
         chk("tile_valid_in_stream", cyc, tile_valid, 0);
         if (lane3 && cyc < 8 && x_rd_en[3]) l3++;
         for (int i = 0; i < N; i++) begin
            ex = req[i] && (m0 + i < j.m) && (nx[i] < j.k);
            ew = req[i] && (c0 + i < j.c) && (nw[i] < j.k);
            chk("x_rd_en", i, x_rd_en[i], ex);
            chk("w_rd_en", i, w_rd_en[i], ew);
            if (ex) begin
               a = j.xb + 32'(((m0 + i) * j.k + nx[i]) * 4);
               chk("x_rd_addr", i, x_rd_addr[i*AW +: AW], a);
               chk("sc_x_data", i, sc_x_data[i*DW +: DW], x_word(a));
               nx[i]++;
            end else begin
               chk("sc_x_data_zero", i, sc_x_data[i*DW +: DW], 0);
            end
            if (ew) begin
               a = j.wb + 32'((nw[i] * j.c + c0 + i) * 4);
               chk("w_rd_addr", i, w_rd_addr[i*AW +: AW], a);
               chk("sc_w_data", i, sc_w_data[i*DW +: DW], w_word(a));
               nw[i]++;
            end else begin
               chk("sc_w_data_zero", i, sc_w_data[i*DW +: DW], 0);
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (lane3) chk("lane3_x_pulses", 3, l3, 5);
      chk("stream_budget", cyc, cyc < 4000, 1);
      sc_valid_queue = '0;
      tile_ready = 1'b0;
   endtask

   task automatic run_job(input job_t j, input int jid);
      int s0, d0, lat, hold, t;
      s0 = smul_cnt;
      d0 = done_cnt;
      t = 0;
      cfg_m = 16'(j.m); cfg_k = 16'(j.k); cfg_cout = 16'(j.c);
      cfg_x_base = j.xb; cfg_w_base = j.wb;
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      @(negedge clk);                       // LOAD
      chk("busy_after_start", jid, busy, 1);
      chk("done_in_load", jid, done, 0);
      if (j.exp_tiles == 0) begin
         @(negedge clk);                    // DONE, two cycles after cfg_start
         chk("done_zero_dim", jid, done, 1);
         chk("busy_zero_dim", jid, busy, 0);
         cfg_start = 1'b1;                  // arrives during DONE: must be ignored
         @(posedge clk); #1;
         cfg_start = 1'b0;
         @(negedge clk);
         chk("start_in_done_ignored", jid, busy, 0);
      end else begin
         for (int mm = 0; mm < j.m; mm += N) begin
            for (int cc = 0; cc < j.c; cc += N) begin
               for (int w = 0; w < 20; w++) begin
                  if (start_mul) break;
                  @(negedge clk);
               end
               chk("start_mul_seen", jid, start_mul, 1);
               chk("busy_in_tile", jid, busy, 1);
               @(negedge clk);
               chk("start_mul_one_cycle", jid, start_mul, 0);
               repeat ($urandom_range(0, 3)) @(negedge clk);
               @(posedge clk); #1;
               stall_mul = 1'b1;
               @(posedge clk); #1;          // now streaming
               stream_tile(mm, cc, j, j.lane3 && t == 0);
               stall_mul = 1'b0;
               lat = 0;
               for (int w = 0; w < 400; w++) begin
                  @(posedge clk);
                  lat++;
                  @(negedge clk);
                  if (tile_valid) break;
               end
               chk("drain_latency", jid, lat, DRAIN + 1);
               chk("tile_m0", jid, tile_m0, 64'(mm));
               chk("tile_c0", jid, tile_c0, 64'(cc));
               hold = (t == j.hold_idx) ? 50 : $urandom_range(0, 2);
               for (int h = 0; h < hold; h++) begin
                  @(negedge clk);
                  chk("offer_hold_valid", h, tile_valid, 1);
                  chk("offer_hold_m0", h, tile_m0, 64'(mm));
                  chk("offer_hold_c0", h, tile_c0, 64'(cc));
                  chk("offer_hold_no_start", h, start_mul, 0);
               end
               @(posedge clk); #1;
               tile_ready = 1'b1;
               @(posedge clk); #1;
               tile_ready = 1'b0;
               @(negedge clk);
               chk("tile_valid_dropped", jid, tile_valid, 0);
               t++;
            end
         end
         for (int w = 0; w < 20; w++) begin
            if (done) break;
            @(negedge clk);
         end
         chk("done_pulse", jid, done, 1);
         chk("busy_at_done", jid, busy, 0);
      end
      @(posedge clk); #1;
      chk("start_mul_count", jid, smul_cnt - s0, j.exp_tiles);
      chk("done_count", jid, done_cnt - d0, 1);
      chk("err_timeout_low", jid, err_timeout, 0);
   endtask

   // Reset asserted while lanes are streaming: everything returns to zero and no done pulse appears.
   task automatic reset_mid_stream();
      int d0;
      d0 = done_cnt;
      cfg_m = 16'd64; cfg_k = 16'd10; cfg_cout = 16'd64;
      cfg_x_base = 32'h0000_4000; cfg_w_base = 32'h0000_8000;
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      for (int w = 0; w < 20; w++) begin
         @(negedge clk);
         if (start_mul) break;
      end
      chk("rst_seq_start_mul", 0, start_mul, 1);
      @(posedge clk); #1;
      stall_mul = 1'b1;
      @(posedge clk); #1;
      sc_valid_queue = '1;
      @(negedge clk);
      chk("rst_seq_all_lanes_read", 0, 64'(x_rd_en), {64{1'b1}});
      #2 n_rst = 1'b0;
      #1 check_idle(1);
      stall_mul = 1'b0;
      sc_valid_queue = '0;
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle(2);
      chk("rst_seq_no_done", 0, done_cnt - d0, 0);
   endtask

   initial begin
      job_t jobs[8];
      jobs[0] = '{128, 363, 32, 32'h0001_0000, 32'h0080_0000, 2, -1, 1'b0};
      jobs[1] = '{70,  5,   70, 32'h0000_1000, 32'h0000_2000, 4,  1, 1'b1};
      jobs[2] = '{5,   0,   5,  32'h0000_0000, 32'h0000_0000, 0, -1, 1'b0};
      jobs[3] = '{0,   4,   4,  32'h0000_0000, 32'h0000_0000, 0, -1, 1'b0};
      jobs[4] = '{3,   2,   0,  32'h0000_0000, 32'h0000_0000, 0, -1, 1'b0};
      jobs[5] = '{10,  3,  130, 32'hFFFF_FFF0, 32'h7FFF_FF00, 3, -1, 1'b0};
      jobs[6] = '{64,  1,   64, 32'h0002_0000, 32'h0003_0000, 1, -1, 1'b0};
      jobs[7] = '{65,  2,   1,  32'h0004_0000, 32'h0005_0000, 2,  0, 1'b0};
      n_rst = 1'b0;
      cfg_start = 1'b0;
      cfg_m = '0; cfg_k = '0; cfg_cout = '0;
      cfg_x_base = '0; cfg_w_base = '0;
      stall_mul = 1'b0;
      sc_valid_queue = '0;
      tile_ready = 1'b0;
      #12;
      check_idle(0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      @(posedge clk); #1;
      reset_mid_stream();
      for (int i = 0; i < 8; i++) run_job(jobs[i], i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
